// File: rtl/softex_pkg.sv
// Shared types and constants for the softex TCDM responder model.
// Defaults here describe the bus seen by the streamer's TCDM initiator port.
package softex_pkg;

    localparam int unsigned TCDM_ADDR_W             = 32;
    localparam int unsigned TCDM_DATA_W             = 64;
    localparam int unsigned TCDM_ID_W               = 1;
    localparam int unsigned TCDM_WAIT_W             = 4;
    localparam int unsigned TCDM_RESP_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [TCDM_DATA_W-1:0] data;
        logic [TCDM_ID_W-1:0]   id;
    } tcdm_resp_t;

    typedef enum logic [0:0] {StIdle, StWait} tcdm_state_e;

endpackage

// File: rtl/softex_tcdm_resp_queue.sv
// Synchronous response FIFO for the TCDM responder; the head is zero while empty.
// The entry type is a parameter so the top can size data/id to its own bus.
module softex_tcdm_resp_queue
    import softex_pkg::*;
#(
    parameter int unsigned DEPTH   = TCDM_RESP_DEPTH_DEFAULT,
    parameter type         entry_t = tcdm_resp_t
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   clear_i,
    input  logic   push_i,
    input  entry_t push_data_i,
    input  logic   pop_i,
    output entry_t head_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               push_ok, pop_ok;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            // DEPTH need not be a power of two, so wrap explicitly
            if (push_ok) begin
                wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                cnt_d = cnt_q + 1'b1;
            end else if (!push_ok && pop_ok) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !clear_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/softex_tcdm_responder.sv
// TCDM target model: byte-enable word memory, programmable grant wait-states,
// in-order response queue with backpressure, access counters and out-of-range flag.
module softex_tcdm_responder
    import softex_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = TCDM_DATA_W,
    parameter int unsigned NUM_WORDS  = 1024,
    parameter int unsigned IW         = TCDM_ID_W,
    parameter int unsigned RESP_DEPTH = TCDM_RESP_DEPTH_DEFAULT,
    parameter int unsigned WAIT_W     = TCDM_WAIT_W
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic [WAIT_W-1:0]       gnt_wait_i,
    output logic [31:0]             rd_count_o,
    output logic [31:0]             wr_count_o,
    output logic                    oob_o,
    input  logic                    tcdm_req_i,
    output logic                    tcdm_gnt_o,
    input  logic [TCDM_ADDR_W-1:0]  tcdm_add_i,
    input  logic                    tcdm_wen_i,
    input  logic [DATA_WIDTH-1:0]   tcdm_data_i,
    input  logic [DATA_WIDTH/8-1:0] tcdm_be_i,
    input  logic [IW-1:0]           tcdm_id_i,
    output logic                    tcdm_r_valid_o,
    output logic [DATA_WIDTH-1:0]   tcdm_r_data_o,
    output logic [IW-1:0]           tcdm_r_id_o,
    input  logic                    tcdm_r_ready_i
);

    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
    localparam int unsigned OFF_W     = $clog2(NUM_BYTES);
    localparam int unsigned IDX_W     = $clog2(NUM_WORDS);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [IW-1:0]         id;
    } resp_t;

    tcdm_state_e         state_q, state_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]    word_idx;
    logic                in_range;
    logic                q_full, q_empty, q_pop;
    logic                grant_rd, grant_wr;
    logic [DATA_WIDTH-1:0] rd_data;
    resp_t               push_entry, head;
    logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
    logic [31:0]         rd_count_q, wr_count_q;
    logic                oob_q;

    // Byte-offset bits are ignored; anything above the word index is out of range
    assign word_idx = tcdm_add_i[OFF_W +: IDX_W];
    assign in_range = ((tcdm_add_i >> (OFF_W + IDX_W)) == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (tcdm_req_i && (gnt_wait_i != '0)) begin
                        state_d = StWait;
                        cnt_d   = gnt_wait_i - 1'b1;
                    end
                end
                StWait: begin
                    if (!tcdm_req_i) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (cnt_q == '0) begin
                        if (!q_full) begin
                            state_d = StIdle;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Grant depends only on current occupancy, never on r_ready
    always_comb begin
        tcdm_gnt_o = 1'b0;
        if (!clear_i && tcdm_req_i && !q_full) begin
            unique case (state_q)
                StIdle:  tcdm_gnt_o = (gnt_wait_i == '0);
                StWait:  tcdm_gnt_o = (cnt_q == '0);
                default: tcdm_gnt_o = 1'b0;
            endcase
        end
    end

    assign grant_rd = tcdm_gnt_o & tcdm_wen_i;
    assign grant_wr = tcdm_gnt_o & ~tcdm_wen_i;

    always_ff @(posedge clk_i) begin
        if (grant_wr && in_range) begin
            for (int unsigned b = 0; b < NUM_BYTES; b++) begin
                if (tcdm_be_i[b]) begin
                    mem_q[word_idx][b*8 +: 8] <= tcdm_data_i[b*8 +: 8];
                end
            end
        end
    end

    assign rd_data    = in_range ? mem_q[word_idx] : '0;
    assign push_entry = '{data: rd_data, id: tcdm_id_i};
    assign q_pop      = tcdm_r_valid_o & tcdm_r_ready_i;

    softex_tcdm_resp_queue #(
        .DEPTH   (RESP_DEPTH),
        .entry_t (resp_t)
    ) i_resp_queue (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .push_i      (grant_rd),
        .push_data_i (push_entry),
        .pop_i       (q_pop),
        .head_o      (head),
        .full_o      (q_full),
        .empty_o     (q_empty)
    );

    assign tcdm_r_valid_o = ~q_empty;
    assign tcdm_r_data_o  = head.data;
    assign tcdm_r_id_o    = head.id;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
            oob_q      <= 1'b0;
        end else if (clear_i) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
            oob_q      <= 1'b0;
        end else begin
            if (grant_rd) begin
                rd_count_q <= rd_count_q + 32'd1;
            end
            if (grant_wr) begin
                wr_count_q <= wr_count_q + 32'd1;
            end
            if (tcdm_gnt_o && !in_range) begin
                oob_q <= 1'b1;
            end
        end
    end

    assign rd_count_o = rd_count_q;
    assign wr_count_o = wr_count_q;
    assign oob_o      = oob_q;

endmodule

// File: tb/tb_softex_tcdm_responder.sv
// Self-checking bench for softex_tcdm_responder (64-bit bus, 1024 words, 4-bit id).
// Read expectations come from a bench-side memory model and are queued at grant.
module tb_softex_tcdm_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  gnt_wait = '0;
    logic [31:0] rd_count, wr_count;
    logic        oob;
    logic        req = 1'b0;
    logic        gnt;
    logic [31:0] add = '0;
    logic        wen = 1'b1;
    logic [63:0] wdata = '0;
    logic [7:0]  be = '0;
    logic [3:0]  id = '0;
    logic        r_valid;
    logic [63:0] r_data;
    logic [3:0]  r_id;
    logic        r_ready = 1'b1;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  id;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] model_mem [1024];
    int          compared = 0;
    int          mismatched = 0;

    softex_tcdm_responder #(
        .DATA_WIDTH (64),
        .NUM_WORDS  (1024),
        .IW         (4),
        .RESP_DEPTH (4),
        .WAIT_W     (4)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .clear_i        (clear),
        .gnt_wait_i     (gnt_wait),
        .rd_count_o     (rd_count),
        .wr_count_o     (wr_count),
        .oob_o          (oob),
        .tcdm_req_i     (req),
        .tcdm_gnt_o     (gnt),
        .tcdm_add_i     (add),
        .tcdm_wen_i     (wen),
        .tcdm_data_i    (wdata),
        .tcdm_be_i      (be),
        .tcdm_id_i      (id),
        .tcdm_r_valid_o (r_valid),
        .tcdm_r_data_o  (r_data),
        .tcdm_r_id_o    (r_id),
        .tcdm_r_ready_i (r_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model_read(input logic [31:0] a);
        if (a[31:13] != 0) return 64'd0;
        return model_mem[a[12:3]];
    endfunction

    // Response monitor: pops the scoreboard on every accepted response
    always @(negedge clk) begin
        if (rst_n && r_valid && r_ready) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_resp: got data=%h id=%h, required none", r_data, r_id);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (r_data !== e.data || r_id !== e.id) begin
                    mismatched++;
                    $display("FAIL resp_data: got data=%h id=%h, required data=%h id=%h",
                             r_data, r_id, e.data, e.id);
                end
            end
        end
    end

    // Issues one access starting just after a posedge; returns just after the posedge
    // that follows the grant, with req still asserted.
    task automatic do_access(input logic w, input logic [31:0] a, input logic [63:0] d,
                             input logic [7:0] b, input logic [3:0] i, output int waited);
        logic done;
        req = 1'b1; wen = w; add = a; wdata = d; be = b; id = i;
        waited = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (gnt === 1'b1) begin
                if (w) begin
                    exp_q.push_back('{data: model_read(a), id: i});
                end else if (a[31:13] == 0) begin
                    for (int k = 0; k < 8; k++)
                        if (b[k]) model_mem[a[12:3]][k*8 +: 8] = d[k*8 +: 8];
                end
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 64) begin
                    compared++;
                    mismatched++;
                    $display("FAIL grant_timeout: got no grant after %0d cycles, required grant", waited);
                    done = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic bus_idle();
        req = 1'b0; wen = 1'b1; be = '0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending responses, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        compared += 5;
        if (r_valid !== 1'b0) begin mismatched++; $display("FAIL rst_r_valid: got %b, required 0", r_valid); end
        if (r_data !== 64'd0 || r_id !== 4'd0) begin
            mismatched++; $display("FAIL rst_r_data: got %h/%h, required 0/0", r_data, r_id);
        end
        if (rd_count !== 32'd0) begin mismatched++; $display("FAIL rst_rd_count: got %0d, required 0", rd_count); end
        if (wr_count !== 32'd0) begin mismatched++; $display("FAIL rst_wr_count: got %0d, required 0", wr_count); end
        if (oob !== 1'b0) begin mismatched++; $display("FAIL rst_oob: got %b, required 0", oob); end
    endtask

    task automatic test_back_to_back();
        int w;
        for (int i = 0; i < 8; i++) begin
            do_access(1'b0, 32'(i * 8), 64'(i), 8'hFF, 4'd0, w);
            compared++;
            if (w != 0) begin mismatched++; $display("FAIL b2b_wr_wait: got %0d, required 0", w); end
        end
        for (int i = 0; i < 8; i++) begin
            do_access(1'b1, 32'(i * 8), 64'd0, 8'h00, 4'(i + 1), w);
            compared++;
            if (w != 0) begin mismatched++; $display("FAIL b2b_rd_wait: got %0d, required 0", w); end
        end
        bus_idle();
        wait_drain();
        compared += 2;
        if (rd_count !== 32'd8) begin mismatched++; $display("FAIL b2b_rd_count: got %0d, required 8", rd_count); end
        if (wr_count !== 32'd8) begin mismatched++; $display("FAIL b2b_wr_count: got %0d, required 8", wr_count); end
    endtask

    task automatic test_latency();
        int w;
        do_access(1'b1, 32'd24, 64'd0, 8'h00, 4'd9, w);
        bus_idle();
        @(negedge clk);
        compared++;
        if (r_valid !== 1'b1) begin mismatched++; $display("FAIL rd_latency: got r_valid=%b, required 1", r_valid); end
        @(posedge clk); #1;
        wait_drain();
    endtask

    task automatic test_byte_enable();
        int w;
        do_access(1'b0, 32'd40, 64'd0, 8'hFF, 4'd0, w);
        do_access(1'b0, 32'd40, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 4'd0, w);
        do_access(1'b1, 32'd40, 64'd0, 8'h00, 4'd2, w);
        bus_idle();
        wait_drain();
    endtask

    task automatic test_wait_states();
        int w;
        logic [31:0] rd0, wr0;
        gnt_wait = 4'd3;
        do_access(1'b1, 32'd8, 64'd0, 8'h00, 4'd3, w);
        bus_idle();
        compared++;
        if (w != 3) begin mismatched++; $display("FAIL wait3_cycles: got %0d waits, required 3", w); end
        wait_drain();
        rd0 = rd_count; wr0 = wr_count;
        req = 1'b1; wen = 1'b1; add = 32'd16; id = 4'd4;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            compared++;
            if (gnt !== 1'b0) begin mismatched++; $display("FAIL wait_early_gnt: got %b, required 0", gnt); end
            @(posedge clk); #1;
        end
        bus_idle();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            compared++;
            if (gnt !== 1'b0) begin mismatched++; $display("FAIL drop_gnt: got %b, required 0", gnt); end
        end
        @(posedge clk); #1;
        compared += 2;
        if (rd_count !== rd0) begin mismatched++; $display("FAIL drop_rd_count: got %0d, required %0d", rd_count, rd0); end
        if (wr_count !== wr0) begin mismatched++; $display("FAIL drop_wr_count: got %0d, required %0d", wr_count, wr0); end
        gnt_wait = 4'd0;
        do_access(1'b1, 32'd16, 64'd0, 8'h00, 4'd4, w);
        bus_idle();
        compared++;
        if (w != 0) begin mismatched++; $display("FAIL drop_back_idle: got %0d waits, required 0", w); end
        wait_drain();
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int cyc = 0;
        r_ready = 1'b0;
        req = 1'b1; wen = 1'b1; add = 32'd0; id = 4'd10;
        while (idx < 6 && cyc < 40) begin
            @(negedge clk);
            if (gnt === 1'b1) begin
                exp_q.push_back('{data: model_read(add), id: id});
                idx++;
            end
            if (!r_ready && r_valid && exp_q.size() != 0) begin
                compared++;
                if (r_data !== exp_q[0].data || r_id !== exp_q[0].id) begin
                    mismatched++;
                    $display("FAIL head_stable: got %h/%h, required %h/%h",
                             r_data, r_id, exp_q[0].data, exp_q[0].id);
                end
            end
            @(posedge clk); #1;
            cyc++;
            if (cyc == 10) begin
                compared++;
                if (idx != 4) begin mismatched++; $display("FAIL stalled_grants: got %0d, required 4", idx); end
                r_ready = 1'b1;
            end
            if (idx < 6) begin
                add = 32'(idx * 8); id = 4'(10 + idx);
            end
        end
        bus_idle();
        compared++;
        if (idx != 6) begin mismatched++; $display("FAIL bp_total_grants: got %0d, required 6", idx); end
        wait_drain();
    endtask

    task automatic test_oob_and_clear();
        int w;
        do_access(1'b1, 32'h0000_2000, 64'd0, 8'h00, 4'd5, w);
        do_access(1'b0, 32'h0000_2028, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 4'd0, w);
        do_access(1'b1, 32'd40, 64'd0, 8'h00, 4'd6, w);
        bus_idle();
        wait_drain();
        compared++;
        if (oob !== 1'b1) begin mismatched++; $display("FAIL oob_set: got %b, required 1", oob); end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        compared += 3;
        if (oob !== 1'b0) begin mismatched++; $display("FAIL clear_oob: got %b, required 0", oob); end
        if (rd_count !== 32'd0) begin mismatched++; $display("FAIL clear_rd_count: got %0d, required 0", rd_count); end
        if (wr_count !== 32'd0) begin mismatched++; $display("FAIL clear_wr_count: got %0d, required 0", wr_count); end
        do_access(1'b1, 32'd24, 64'd0, 8'h00, 4'd7, w);
        bus_idle();
        wait_drain();
    endtask

    task automatic test_clear_priority();
        int w;
        req = 1'b1; wen = 1'b0; add = 32'd48; wdata = 64'hAAAA_AAAA_AAAA_AAAA; be = 8'hFF;
        clear = 1'b1;
        @(negedge clk);
        compared++;
        if (gnt !== 1'b0) begin mismatched++; $display("FAIL clear_gnt: got %b, required 0", gnt); end
        @(posedge clk); #1;
        clear = 1'b0;
        bus_idle();
        compared++;
        if (wr_count !== 32'd0) begin mismatched++; $display("FAIL clear_no_write: got %0d, required 0", wr_count); end
        do_access(1'b1, 32'd48, 64'd0, 8'h00, 4'd8, w);
        bus_idle();
        wait_drain();
    endtask

    task automatic test_reset_midflight();
        int w;
        r_ready = 1'b0;
        for (int i = 0; i < 3; i++) do_access(1'b1, 32'(i * 8), 64'd0, 8'h00, 4'(i), w);
        bus_idle();
        @(negedge clk);
        compared++;
        if (r_valid !== 1'b1) begin mismatched++; $display("FAIL pre_rst_valid: got %b, required 1", r_valid); end
        #2 rst_n = 1'b0;
        #1;
        compared += 2;
        if (r_valid !== 1'b0) begin mismatched++; $display("FAIL async_rst_valid: got %b, required 0", r_valid); end
        if (gnt !== 1'b0) begin mismatched++; $display("FAIL async_rst_gnt: got %b, required 0", gnt); end
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        r_ready = 1'b1;
        compared++;
        if (rd_count !== 32'd0) begin mismatched++; $display("FAIL post_rst_count: got %0d, required 0", rd_count); end
        do_access(1'b0, 32'd16, 64'h0000_0000_0000_1234, 8'hFF, 4'd0, w);
        do_access(1'b1, 32'd16, 64'd0, 8'h00, 4'd7, w);
        bus_idle();
        wait_drain();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) model_mem[i] = 64'd0;
        test_reset();
        test_back_to_back();
        test_latency();
        test_byte_enable();
        test_wait_states();
        test_backpressure();
        test_oob_and_clear();
        test_clear_priority();
        test_reset_midflight();
        repeat (3) @(posedge clk);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL final_scoreboard: got %0d pending, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
